// File: rtl/arcade_input_cond_pkg.sv
// Shared constants for the arcade input conditioner: scan codes, key indices,
// coin FSM states, joystick bit positions and the scan-code decoder.
package arcade_input_pkg;

  localparam logic [7:0] SC_P1_UP     = 8'h75;
  localparam logic [7:0] SC_P1_DOWN   = 8'h72;
  localparam logic [7:0] SC_P1_LEFT   = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT  = 8'h74;
  localparam logic [7:0] SC_P1_FIREA  = 8'h14;
  localparam logic [7:0] SC_P1_FIREB  = 8'h11;
  localparam logic [7:0] SC_P1_FIREC  = 8'h29;
  localparam logic [7:0] SC_P1_FIRED  = 8'h12;
  localparam logic [7:0] SC_COIN1_A   = 8'h76;
  localparam logic [7:0] SC_COIN1_B   = 8'h2E;
  localparam logic [7:0] SC_COIN2     = 8'h36;
  localparam logic [7:0] SC_START1_A  = 8'h05;
  localparam logic [7:0] SC_START1_B  = 8'h16;
  localparam logic [7:0] SC_START2_A  = 8'h06;
  localparam logic [7:0] SC_START2_B  = 8'h1E;
  localparam logic [7:0] SC_P2_UP     = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN   = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT   = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT  = 8'h34;
  localparam logic [7:0] SC_P2_FIREA  = 8'h1C;
  localparam logic [7:0] SC_P2_FIREB  = 8'h1B;
  localparam logic [7:0] SC_P2_FIREC  = 8'h15;
  localparam logic [7:0] SC_P2_FIRED  = 8'h1D;

  localparam int NUM_KEYS = 20;

  // Index order matches the {fireD..right} control byte so P1/P2 are slices.
  typedef enum logic [4:0] {
    K_P1_RIGHT = 5'd0,  K_P1_LEFT  = 5'd1,  K_P1_DOWN  = 5'd2,  K_P1_UP    = 5'd3,
    K_P1_FIREA = 5'd4,  K_P1_FIREB = 5'd5,  K_P1_FIREC = 5'd6,  K_P1_FIRED = 5'd7,
    K_P2_RIGHT = 5'd8,  K_P2_LEFT  = 5'd9,  K_P2_DOWN  = 5'd10, K_P2_UP    = 5'd11,
    K_P2_FIREA = 5'd12, K_P2_FIREB = 5'd13, K_P2_FIREC = 5'd14, K_P2_FIRED = 5'd15,
    K_COIN1    = 5'd16, K_COIN2    = 5'd17, K_START1   = 5'd18, K_START2   = 5'd19
  } key_idx_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    GAP      = 2'd2,
    WAIT_REL = 2'd3
  } coin_state_e;

  localparam int JOY_CTL_MSB = 7;
  localparam int JOY_START1  = 8;
  localparam int JOY_START2  = 9;
  localparam int JOY_COIN    = 10;

  typedef struct packed {
    logic     hit;
    key_idx_e idx;
  } key_hit_t;

  function automatic key_hit_t decode_scan(input logic [7:0] code);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = K_P1_RIGHT;
    case (code)
      SC_P1_UP:    r.idx = K_P1_UP;
      SC_P1_DOWN:  r.idx = K_P1_DOWN;
      SC_P1_LEFT:  r.idx = K_P1_LEFT;
      SC_P1_RIGHT: r.idx = K_P1_RIGHT;
      SC_P1_FIREA: r.idx = K_P1_FIREA;
      SC_P1_FIREB: r.idx = K_P1_FIREB;
      SC_P1_FIREC: r.idx = K_P1_FIREC;
      SC_P1_FIRED: r.idx = K_P1_FIRED;
      SC_COIN1_A:  r.idx = K_COIN1;
      SC_COIN1_B:  r.idx = K_COIN1;
      SC_COIN2:    r.idx = K_COIN2;
      SC_START1_A: r.idx = K_START1;
      SC_START1_B: r.idx = K_START1;
      SC_START2_A: r.idx = K_START2;
      SC_START2_B: r.idx = K_START2;
      SC_P2_UP:    r.idx = K_P2_UP;
      SC_P2_DOWN:  r.idx = K_P2_DOWN;
      SC_P2_LEFT:  r.idx = K_P2_LEFT;
      SC_P2_RIGHT: r.idx = K_P2_RIGHT;
      SC_P2_FIREA: r.idx = K_P2_FIREA;
      SC_P2_FIREB: r.idx = K_P2_FIREB;
      SC_P2_FIREC: r.idx = K_P2_FIREC;
      SC_P2_FIRED: r.idx = K_P2_FIRED;
      default:     r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arcade_input_cond_if.sv
// Bundle of keyboard/joystick inputs and conditioned control outputs
// between the arcade top level and the input conditioner.
interface arcade_input_cond_if;
  logic [10:0] ps2_key;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic        clr;
  logic [7:0]  p1_ctl;
  logic [7:0]  p2_ctl;
  logic [7:0]  any_ctl;
  logic        start1;
  logic        start2;
  logic        coin_raw;
  logic        coin_pulse;

  modport master (
    output ps2_key, joy1, joy2, clr,
    input  p1_ctl, p2_ctl, any_ctl, start1, start2, coin_raw, coin_pulse
  );

  modport slave (
    input  ps2_key, joy1, joy2, clr,
    output p1_ctl, p2_ctl, any_ctl, start1, start2, coin_raw, coin_pulse
  );
endinterface

// File: rtl/arcade_input_cond_coin_shaper.sv
// Turns rising edges of the merged coin signal into one fixed-width pulse,
// followed by a lockout gap and a wait for the coin source to release.
module coin_shaper
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE = 2400000,
  parameter int COIN_GAP   = 2400000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic coin_raw_i,
  output logic coin_pulse_o
);

  localparam int MAX_CNT = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int CW = (MAX_CNT + 1 > 1) ? $clog2(MAX_CNT + 1) : 1;
  localparam int GAP_LOAD_I = (COIN_GAP > 0) ? COIN_GAP - 1 : 0;
  localparam logic [CW-1:0] PULSE_LOAD = CW'(COIN_PULSE - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_LOAD_I);

  coin_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          coin_dly_q;
  logic          rise_s;

  assign rise_s       = coin_raw_i & ~coin_dly_q;
  assign coin_pulse_o = pulse_q;

  // State, counter, pulse and edge-detect registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
      coin_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      coin_dly_q <= coin_raw_i;
    end
  end

  // Next-state logic; counters only decrement while nonzero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          cnt_d   = PULSE_LOAD;
          pulse_d = 1'b1;
          state_d = PULSE;
        end else begin
          pulse_d = 1'b0;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          pulse_d = 1'b0;
          if (COIN_GAP == 0) begin
            state_d = WAIT_REL;
          end else begin
            cnt_d   = GAP_LOAD;
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = WAIT_REL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT_REL: begin
        if (!coin_raw_i) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_REL;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pulse_d = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/arcade_input_cond.sv
// Keyboard decode into held-key state, OR-merge with both joysticks into
// registered player controls, and coin conditioning via coin_shaper.
module arcade_input_cond
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE = 2400000,
  parameter int COIN_GAP   = 2400000
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  arcade_input_cond_if.slave  bus
);

  logic                tog_q;
  logic                primed_q;
  logic [NUM_KEYS-1:0] key_q, key_d;
  logic                event_s;
  key_hit_t            hit_s;

  logic [7:0] p1_ctl_q, p1_ctl_d;
  logic [7:0] p2_ctl_q, p2_ctl_d;
  logic [7:0] any_ctl_q;
  logic       start1_q, start1_d;
  logic       start2_q, start2_d;
  logic       coin_raw_q, coin_raw_d;
  logic       coin_pulse_s;
  logic       unused_s;

  // The extended flag and upper joystick bits carry nothing for this stage.
  assign unused_s = ^{bus.ps2_key[8], bus.joy1[15:11], bus.joy2[15:11]};

  assign event_s = primed_q & (bus.ps2_key[10] != tog_q);
  assign hit_s   = decode_scan(bus.ps2_key[7:0]);

  // Held-key next state: clr wins over any same-cycle event.
  always_comb begin
    key_d = key_q;
    if (bus.clr) begin
      key_d = '0;
    end else if (event_s && hit_s.hit) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (int'(hit_s.idx) == i) begin
          key_d[i] = bus.ps2_key[9];
        end
      end
    end else begin
      key_d = key_q;
    end
  end

  // Toggle tracking is primed on the first edge so a stale toggle is not an event.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q    <= 1'b0;
      primed_q <= 1'b0;
      key_q    <= '0;
    end else begin
      tog_q    <= bus.ps2_key[10];
      primed_q <= 1'b1;
      key_q    <= key_d;
    end
  end

  assign p1_ctl_d   = key_q[JOY_CTL_MSB:0] | bus.joy1[JOY_CTL_MSB:0];
  assign p2_ctl_d   = key_q[K_P2_FIRED:K_P2_RIGHT] | bus.joy2[JOY_CTL_MSB:0];
  assign start1_d   = key_q[K_START1] | bus.joy1[JOY_START1] | bus.joy2[JOY_START1];
  assign start2_d   = key_q[K_START2] | bus.joy1[JOY_START2] | bus.joy2[JOY_START2];
  assign coin_raw_d = key_q[K_COIN1] | key_q[K_COIN2]
                    | bus.joy1[JOY_COIN] | bus.joy2[JOY_COIN];

  // Registered control outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      p1_ctl_q   <= 8'h00;
      p2_ctl_q   <= 8'h00;
      any_ctl_q  <= 8'h00;
      start1_q   <= 1'b0;
      start2_q   <= 1'b0;
      coin_raw_q <= 1'b0;
    end else begin
      p1_ctl_q   <= p1_ctl_d;
      p2_ctl_q   <= p2_ctl_d;
      any_ctl_q  <= p1_ctl_d | p2_ctl_d;
      start1_q   <= start1_d;
      start2_q   <= start2_d;
      coin_raw_q <= coin_raw_d;
    end
  end

  coin_shaper #(
    .COIN_PULSE (COIN_PULSE),
    .COIN_GAP   (COIN_GAP)
  ) u_coin_shaper (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .coin_raw_i   (coin_raw_q),
    .coin_pulse_o (coin_pulse_s)
  );

  assign bus.p1_ctl     = p1_ctl_q;
  assign bus.p2_ctl     = p2_ctl_q;
  assign bus.any_ctl    = any_ctl_q;
  assign bus.start1     = start1_q;
  assign bus.start2     = start2_q;
  assign bus.coin_raw   = coin_raw_q;
  assign bus.coin_pulse = coin_pulse_s;

endmodule
